// File: rtl/pre_ex_forward_stage.sv
// Pre-execute stage: holds one decoded instruction, resolves both source operands
// against prioritised forwarding sources (waiting on pending producers) and hands off to EX.

module pre_ex_opnd_resolve #(
  parameter int WIDTH   = 32,
  parameter int REG_W   = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_W-1:0]                  rs,
  input  logic [WIDTH-1:0]                  rf_data,
  input  logic [NUM_FWD-1:0]                fwd_valid,
  input  logic [NUM_FWD-1:0]                fwd_pending,
  input  logic [NUM_FWD-1:0][REG_W-1:0]     fwd_reg,
  input  logic [NUM_FWD-1:0][WIDTH-1:0]     fwd_data,
  output logic                              resolved,
  output logic [WIDTH-1:0]                  value
);
  logic hit;

  // Lowest index is the youngest producer, so the first match wins.
  always_comb begin
    hit      = 1'b0;
    resolved = 1'b1;
    value    = rf_data;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_valid[i] && fwd_reg[i] == rs) begin
        hit      = 1'b1;
        resolved = !fwd_pending[i];
        value    = fwd_data[i];
      end
    end
    if (rs == '0) begin
      resolved = 1'b1;
      value    = '0;
    end
  end
endmodule

module pre_ex_forward_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_W      = 5,
  parameter int NUM_FWD    = 3,
  parameter int PAYLOAD_W  = 64,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clkEn,
  input  logic                        flush,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [REG_W-1:0]            inRs1,
  input  logic [REG_W-1:0]            inRs2,
  input  logic [WIDTH-1:0]            inRs1Data,
  input  logic [WIDTH-1:0]            inRs2Data,
  input  logic [PAYLOAD_W-1:0]        inPayload,
  input  logic [NUM_FWD-1:0]          fwdValid,
  input  logic [NUM_FWD-1:0]          fwdPending,
  input  logic [NUM_FWD*REG_W-1:0]    fwdReg,
  input  logic [NUM_FWD*WIDTH-1:0]    fwdData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [WIDTH-1:0]            outOp1,
  output logic [WIDTH-1:0]            outOp2,
  output logic [PAYLOAD_W-1:0]        outPayload,
  output logic [WAIT_CNT_W-1:0]       outWaitCycles
);
  localparam int NOPS = 2;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  state_t                          state, state_nxt;
  logic [NOPS-1:0][REG_W-1:0]      in_rs, rs_q, res_rs;
  logic [NOPS-1:0][WIDTH-1:0]      in_rf, rf_q, res_rf, res_val, op_q;
  logic [NOPS-1:0]                 res_ok, lock_q;
  logic [NUM_FWD-1:0][REG_W-1:0]   fwd_reg;
  logic [NUM_FWD-1:0][WIDTH-1:0]   fwd_data;
  logic                            accept, xfer, all_res_wait;

  assign fwd_reg  = fwdReg;
  assign fwd_data = fwdData;
  assign in_rs    = {inRs2, inRs1};
  assign in_rf    = {inRs2Data, inRs1Data};

  assign inReady = clkEn && !flush &&
                   (state == S_EMPTY || (state == S_FULL && outReady));
  assign accept  = inValid && inReady;
  assign xfer    = outValid && outReady && clkEn;

  // Resolvers see the incoming instruction on accept, otherwise the held one.
  assign res_rs = accept ? in_rs : rs_q;
  assign res_rf = accept ? in_rf : rf_q;

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    pre_ex_opnd_resolve #(
      .WIDTH   (WIDTH),
      .REG_W   (REG_W),
      .NUM_FWD (NUM_FWD)
    ) u_res (
      .rs          (res_rs[g]),
      .rf_data     (res_rf[g]),
      .fwd_valid   (fwdValid),
      .fwd_pending (fwdPending),
      .fwd_reg     (fwd_reg),
      .fwd_data    (fwd_data),
      .resolved    (res_ok[g]),
      .value       (res_val[g])
    );
  end

  assign all_res_wait = &(lock_q | res_ok);
  assign outOp1       = op_q[0];
  assign outOp2       = op_q[1];

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else if (clkEn) begin
      if (accept)
        state_nxt = (&res_ok) ? S_FULL : S_WAIT;
      else if (xfer)
        state_nxt = S_EMPTY;
      else if (state == S_WAIT && all_res_wait)
        state_nxt = S_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_EMPTY;
      outValid <= 1'b0;
    end else begin
      state    <= state_nxt;
      outValid <= (state_nxt == S_FULL);
    end
  end

  // Data path: flush only kills the state, held data stays as it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q          <= '0;
      rf_q          <= '0;
      lock_q        <= '0;
      op_q          <= '0;
      outPayload    <= '0;
      outWaitCycles <= '0;
    end else if (!flush && clkEn) begin
      if (accept) begin
        rs_q          <= in_rs;
        rf_q          <= in_rf;
        lock_q        <= res_ok;
        outPayload    <= inPayload;
        outWaitCycles <= '0;
        for (int k = 0; k < NOPS; k++)
          if (res_ok[k]) op_q[k] <= res_val[k];
      end else if (state == S_WAIT) begin
        for (int k = 0; k < NOPS; k++) begin
          if (!lock_q[k] && res_ok[k]) begin
            lock_q[k] <= 1'b1;
            op_q[k]   <= res_val[k];
          end
        end
        if (outWaitCycles != '1)
          outWaitCycles <= outWaitCycles + WAIT_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pre_ex_forward_stage.sv
// Bench for pre_ex_forward_stage: table-driven streaming vectors plus hand sequences,
// with a scoreboard queue checked whenever the stage hands an instruction to EX.

module tb_pre_ex_forward_stage;
  logic         clk = 1'b0;
  logic         rst, clkEn, flush, inValid, inReady, outValid, outReady;
  logic [4:0]   inRs1, inRs2;
  logic [31:0]  inRs1Data, inRs2Data, outOp1, outOp2;
  logic [63:0]  inPayload, outPayload;
  logic [2:0]   fwdValid, fwdPending;
  logic [14:0]  fwdReg;
  logic [95:0]  fwdData;
  logic [3:0]   outWaitCycles;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic [2:0]  fv, fp;
    logic [14:0] freg;
    logic [95:0] fdata;
    logic [63:0] pl;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    logic [31:0] op1, op2;
    logic [63:0] pl;
    logic [3:0]  wt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pre_ex_forward_stage #(
    .WIDTH(32), .REG_W(5), .NUM_FWD(3), .PAYLOAD_W(64), .WAIT_CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .inRs1(inRs1), .inRs2(inRs2), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
    .inPayload(inPayload),
    .fwdValid(fwdValid), .fwdPending(fwdPending), .fwdReg(fwdReg), .fwdData(fwdData),
    .outValid(outValid), .outReady(outReady),
    .outOp1(outOp1), .outOp2(outOp2), .outPayload(outPayload),
    .outWaitCycles(outWaitCycles)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] rf1, input logic [31:0] rf2,
                               input logic [2:0] fv, input logic [2:0] fp,
                               input logic [14:0] freg, input logic [95:0] fdata,
                               input logic [63:0] pl,
                               input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rf1 = rf1; v.rf2 = rf2;
    v.fv = fv; v.fp = fp; v.freg = freg; v.fdata = fdata;
    v.pl = pl; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    inRs1 = v.rs1; inRs2 = v.rs2; inRs1Data = v.rf1; inRs2Data = v.rf2;
    fwdValid = v.fv; fwdPending = v.fp; fwdReg = v.freg; fwdData = v.fdata;
    inPayload = v.pl;
  endtask

  task automatic idle();
    inValid = 1'b0; fwdValid = '0; fwdPending = '0; fwdReg = '0; fwdData = '0;
  endtask

  // Offer v until accepted (bounded); optionally record its expected EX result.
  task automatic send(input vec_t v, input int wexp, input bit push, output int tries);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    tries = 0;
    drive(v);
    inValid = 1'b1;
    e.op1 = v.e1; e.op2 = v.e2; e.pl = v.pl; e.wt = 4'(wexp);
    while (!ok && tries < 50) begin
      @(negedge clk);
      tries++;
      ok = inReady;
      if (ok && push) sbq.push_back(e);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: got no accept after %0d cycles expected accept", tries);
    end
  endtask

  always @(negedge clk) begin
    if (rst && clkEn && !flush && outValid && outReady) begin
      if (sbq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: got op1 %0h payload %0h expected no output", outOp1, outPayload);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_op1", 64'(outOp1), 64'(mon_e.op1));
        chk("out_op2", 64'(outOp2), 64'(mon_e.op2));
        chk("out_payload", outPayload, mon_e.pl);
        chk("out_wait", 64'(outWaitCycles), 64'(mon_e.wt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   tries;

    vecs[0] = mkv(5'd3, 5'd0, 32'h11, 32'h55, 3'b000, 3'b000, '0, '0,
                  64'hA000_0000_0000_0000, 32'h11, 32'h0);
    vecs[1] = mkv(5'd5, 5'd5, 32'h1, 32'h2, 3'b101, 3'b000, {5'd5, 5'd0, 5'd5},
                  {32'hBB, 32'h0, 32'hAA}, 64'hA000_0000_0000_0001, 32'hAA, 32'hAA);
    vecs[2] = mkv(5'd4, 5'd6, 32'h4, 32'h6, 3'b110, 3'b000, {5'd6, 5'd4, 5'd0},
                  {32'hD6, 32'hC4, 32'h0}, 64'hA000_0000_0000_0002, 32'hC4, 32'hD6);
    vecs[3] = mkv(5'd9, 5'd0, 32'h99, 32'h77, 3'b010, 3'b000, {5'd0, 5'd0, 5'd9},
                  {32'h0, 32'hFF, 32'hEE}, 64'hA000_0000_0000_0003, 32'h99, 32'h0);
    vecs[4] = mkv(5'd8, 5'd2, 32'h88, 32'h20, 3'b110, 3'b011, {5'd2, 5'd3, 5'd8},
                  {32'h22, 32'h33, 32'hE8}, 64'hA000_0000_0000_0004, 32'h88, 32'h22);
    vecs[5] = mkv(5'd31, 5'd31, 32'h1F, 32'h2F, 3'b001, 3'b000, {5'd0, 5'd0, 5'd31},
                  {32'h0, 32'h0, 32'h31}, 64'hA000_0000_0000_0005, 32'h31, 32'h31);

    rst = 1'b0; clkEn = 1'b1; flush = 1'b0; outReady = 1'b1;
    drive(vecs[0]);
    inValid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outvalid", 64'(outValid), 64'd0);
    chk("rst_op1", 64'(outOp1), 64'd0);
    chk("rst_op2", 64'(outOp2), 64'd0);
    chk("rst_payload", outPayload, 64'd0);
    chk("rst_wait", 64'(outWaitCycles), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // Back-to-back stream of resolvable instructions, one accept per cycle.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], 0, 1'b1, tries);
      chk("stream_accept_cycles", 64'(tries), 64'd1);
    end
    idle();
    @(negedge clk);
    chk("stream_last_valid", 64'(outValid), 64'd1);
    @(posedge clk); #1;

    // Pending producer: two pending WAIT cycles, data on the third.
    v = mkv(5'd7, 5'd0, 32'h7, 32'h0, 3'b010, 3'b010, {5'd0, 5'd7, 5'd0}, '0,
            64'hB000_0000_0000_0007, 32'h1234, 32'h0);
    send(v, 3, 1'b1, tries);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        fwdPending = 3'b000;
        fwdData    = {32'h0, 32'h1234, 32'h0};
      end
      @(negedge clk);
      chk("wait_inready", 64'(inReady), 64'd0);
      chk("wait_outvalid", 64'(outValid), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pend_outvalid", 64'(outValid), 64'd1);
    @(posedge clk); #1;
    idle();

    // Saturating wait counter.
    v = mkv(5'd0, 5'd12, 32'h0, 32'hC, 3'b001, 3'b001, {5'd0, 5'd0, 5'd12}, '0,
            64'hB000_0000_0000_000C, 32'h0, 32'h5A5A);
    send(v, 15, 1'b1, tries);
    for (int k = 0; k < 21; k++) begin
      if (k == 20) begin
        fwdPending = 3'b000;
        fwdData    = {32'h0, 32'h0, 32'h5A5A};
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("sat_outvalid", 64'(outValid), 64'd1);
    @(posedge clk); #1;
    idle();

    // Back-pressure, then streaming resumes.
    outReady = 1'b0;
    v = mkv(5'd1, 5'd2, 32'h101, 32'h202, 3'b000, 3'b000, '0, '0,
            64'hC000_0000_0000_0001, 32'h101, 32'h202);
    send(v, 0, 1'b1, tries);
    v = mkv(5'd3, 5'd4, 32'h303, 32'h404, 3'b000, 3'b000, '0, '0,
            64'hC000_0000_0000_0002, 32'h303, 32'h404);
    drive(v);
    inValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_inready", 64'(inReady), 64'd0);
      chk("bp_outvalid", 64'(outValid), 64'd1);
      chk("bp_op1_stable", 64'(outOp1), 64'h101);
      chk("bp_payload_stable", outPayload, 64'hC000_0000_0000_0001);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = mkv(5'(k + 3), 5'(k + 4), 32'(k + 32'h303), 32'(k + 32'h404), 3'b000, 3'b000,
              '0, '0, 64'hC000_0000_0000_0002 + 64'(k), 32'(k + 32'h303), 32'(k + 32'h404));
      send(v, 0, 1'b1, tries);
      chk("resume_accept_cycles", 64'(tries), 64'd1);
    end
    idle();
    repeat (2) @(posedge clk); #1;

    // Flush during WAIT coincident with a new instruction: both are dropped.
    v = mkv(5'd10, 5'd0, 32'hA, 32'h0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd10}, '0,
            64'hD000_0000_0000_000A, 32'h0, 32'h0);
    send(v, 0, 1'b0, tries);
    v = mkv(5'd11, 5'd0, 32'hB, 32'h0, 3'b000, 3'b000, '0, '0,
            64'hD000_0000_0000_000B, 32'hB, 32'h0);
    drive(v);
    fwdValid = 3'b001; fwdPending = 3'b001; fwdReg = {5'd0, 5'd0, 5'd10};
    inValid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_inready", 64'(inReady), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    inValid = 1'b0;
    fwdPending = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_outvalid", 64'(outValid), 64'd0);
      @(posedge clk); #1;
    end
    idle();

    // clkEn low mid-stream: no transfers, outputs frozen, fwd inputs ignored.
    v = mkv(5'd13, 5'd14, 32'hD13, 32'hE14, 3'b000, 3'b000, '0, '0,
            64'hE000_0000_0000_0001, 32'hD13, 32'hE14);
    send(v, 0, 1'b1, tries);
    v = mkv(5'd15, 5'd16, 32'hF15, 32'h116, 3'b000, 3'b000, '0, '0,
            64'hE000_0000_0000_0002, 32'hF15, 32'h116);
    drive(v);
    inValid = 1'b1;
    clkEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fwdValid = 3'b111; fwdReg = {5'd13, 5'd14, 5'd15}; fwdData = {3{$urandom()}};
      @(negedge clk);
      chk("cen_inready", 64'(inReady), 64'd0);
      chk("cen_outvalid", 64'(outValid), 64'd1);
      chk("cen_op1_frozen", 64'(outOp1), 64'hD13);
      chk("cen_op2_frozen", 64'(outOp2), 64'hE14);
      @(posedge clk); #1;
    end
    clkEn = 1'b1;
    fwdValid = '0;
    send(v, 0, 1'b1, tries);
    chk("cen_resume_cycles", 64'(tries), 64'd1);
    idle();
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset while waiting clears outputs immediately.
    v = mkv(5'd17, 5'd0, 32'h17, 32'h0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd17}, '0,
            64'hF000_0000_0000_0011, 32'h0, 32'h0);
    send(v, 0, 1'b0, tries);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_outvalid", 64'(outValid), 64'd0);
    chk("arst_op1", 64'(outOp1), 64'd0);
    chk("arst_payload", outPayload, 64'd0);
    chk("arst_wait", 64'(outWaitCycles), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    fwdPending = 3'b000;
    repeat (3) @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("arst_no_emit", 64'(outValid), 64'd0);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
